// File: rtl/latency_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// latency_counter: trigger-to-light latency meter; optional stats: LATENCY_STATS_EN
// Revision: 1.0
// ============================================================================
module latency_counter #(
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd150_000_000,
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        starttrigger,
    input  logic        sensor,
    output logic [31:0] latency,
    output logic        latency_valid,
    output logic        timeout,
    output logic        busy,
    output logic [31:0] lat_min,
    output logic [31:0] lat_max,
    output logic [15:0] lat_count
);
    localparam logic [31:0] PIPE_DELAY = 32'(SYNC_STAGES + DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTING  = 2'd1,
        WAIT_DARK = 2'd2
    } state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   deb_level;
    logic                   deb_rise;
    logic [7:0]             deb_run;
    logic [31:0]            count;
    logic [31:0]            measured;
    logic                   meas_done;
    logic                   meas_timeout;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign busy     = (state != IDLE);
    // Remove synchroniser + debounce delay so the result references the first sync flop.
    assign measured = (count >= PIPE_DELAY) ? (count - PIPE_DELAY) : 32'd0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            deb_level <= 1'b0;
            deb_run   <= '0;
            deb_rise  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], sensor};
            deb_rise <= 1'b0;
            if (sync_out == deb_level) begin
                deb_run <= '0;
            end else if (deb_run == DEB_LAST) begin
                deb_level <= sync_out;
                deb_run   <= '0;
                deb_rise  <= sync_out;
            end else begin
                deb_run <= deb_run + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_DARK;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        meas_done    = 1'b0;
        meas_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (starttrigger) begin
                    state_next = COUNTING;
                end
            end
            COUNTING: begin
                if (deb_rise) begin
                    meas_done  = 1'b1;
                    state_next = WAIT_DARK;
                end else if (count == TIMEOUT_CYCLES) begin
                    meas_timeout = 1'b1;
                    state_next   = WAIT_DARK;
                end
            end
            WAIT_DARK: begin
                if (!deb_level) begin
                    state_next = IDLE;
                end
            end
            default: state_next = WAIT_DARK;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count         <= '0;
            latency       <= '0;
            latency_valid <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            latency_valid <= meas_done | meas_timeout;
            timeout       <= meas_timeout;
            if (state == IDLE && starttrigger) begin
                count <= '0;
            end else if (state == COUNTING && count != TIMEOUT_CYCLES) begin
                count <= count + 32'd1;
            end
            if (meas_done) begin
                latency <= measured;
            end else if (meas_timeout) begin
                latency <= 32'hFFFF_FFFF;
            end
        end
    end

`ifdef LATENCY_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lat_min   <= 32'hFFFF_FFFF;
            lat_max   <= '0;
            lat_count <= '0;
        end else if (meas_done) begin
            if (measured < lat_min) begin
                lat_min <= measured;
            end
            if (measured > lat_max) begin
                lat_max <= measured;
            end
            if (lat_count != 16'hFFFF) begin
                lat_count <= lat_count + 16'd1;
            end
        end
    end
`else
    assign lat_min   = '0;
    assign lat_max   = '0;
    assign lat_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_latency_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_latency_counter: directed bench with hand-computed latencies.
// Revision: 1.0
// ============================================================================
module tb_latency_counter;
    localparam logic [31:0] TIMEOUT_CYCLES = 32'd2000;
`ifdef LATENCY_STATS_EN
    localparam logic [31:0] RST_MIN   = 32'hFFFF_FFFF;
    localparam logic [31:0] EXP_MIN   = 32'd900;
    localparam logic [31:0] EXP_MAX   = 32'd1500;
    localparam logic [31:0] EXP_COUNT = 32'd3;
`else
    localparam logic [31:0] RST_MIN   = 32'd0;
    localparam logic [31:0] EXP_MIN   = 32'd0;
    localparam logic [31:0] EXP_MAX   = 32'd0;
    localparam logic [31:0] EXP_COUNT = 32'd0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        starttrigger = 1'b0;
    logic        sensor = 1'b0;
    logic [31:0] latency;
    logic        latency_valid;
    logic        timeout;
    logic        busy;
    logic [31:0] lat_min;
    logic [31:0] lat_max;
    logic [15:0] lat_count;

    int checks = 0;
    int errors = 0;

    latency_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .starttrigger (starttrigger),
        .sensor       (sensor),
        .latency      (latency),
        .latency_valid(latency_valid),
        .timeout      (timeout),
        .busy         (busy),
        .lat_min      (lat_min),
        .lat_max      (lat_max),
        .lat_count    (lat_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    // Called at a negedge; the following posedge is E0.
    task automatic pulse_trigger();
        starttrigger = 1'b1;
        @(negedge clock);
        starttrigger = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int n);
        logic seen;
        seen = 1'b0;
        n    = 0;
        while (n < max && !seen) begin
            @(negedge clock);
            n++;
            seen = latency_valid;
        end
        if (!seen) begin
            check_eq("valid_seen", 32'd0, 32'd1);
        end
    endtask

    // Light reaches the first sync flop at edge E(at); strobe follows 7 negedges later.
    task automatic measure(input string tag, input int at, input logic [31:0] exp);
        int n;
        pulse_trigger();
        repeat (at - 1) @(negedge clock);
        sensor = 1'b1;
        wait_valid(40, n);
        check_eq({tag, "_latency"}, latency, exp);
        check_eq({tag, "_timeout"}, 32'(timeout), 32'd0);
        check_eq({tag, "_strobe_delay"}, 32'(n), 32'd7);
    endtask

    // Dark reaches the debounced level after 6 edges; IDLE one edge later.
    task automatic go_dark(input string tag);
        sensor = 1'b0;
        repeat (6) @(negedge clock);
        check_eq({tag, "_busy_hold"}, 32'(busy), 32'd1);
        @(negedge clock);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int stray;

        repeat (3) @(negedge clock);
        check_eq("rst_latency", latency, 32'd0);
        check_eq("rst_valid", 32'(latency_valid), 32'd0);
        check_eq("rst_timeout", 32'(timeout), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd1);
        check_eq("rst_lat_min", lat_min, RST_MIN);
        check_eq("rst_lat_max", lat_max, 32'd0);
        check_eq("rst_lat_count", 32'(lat_count), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check_eq("rst_release_idle", 32'(busy), 32'd0);

        // Statistics sequence: 1200, 900, timeout, 1500.
        measure("m1200", 1200, 32'd1200);
        go_dark("m1200");
        measure("m900", 900, 32'd900);
        go_dark("m900");
        pulse_trigger();
        wait_valid(2100, n);
        check_eq("to_delay", 32'(n), 32'd2001);
        check_eq("to_latency", latency, 32'hFFFF_FFFF);
        check_eq("to_flag", 32'(timeout), 32'd1);
        @(negedge clock);
        check_eq("to_valid_single", 32'(latency_valid), 32'd0);
        check_eq("to_idle", 32'(busy), 32'd0);
        measure("m1500", 1500, 32'd1500);
        go_dark("m1500");
        check_eq("stat_min", lat_min, EXP_MIN);
        check_eq("stat_max", lat_max, EXP_MAX);
        check_eq("stat_count", 32'(lat_count), EXP_COUNT);

        // Nominal, then a trigger while still light must be ignored.
        measure("nom", 1000, 32'd1000);
        @(negedge clock);
        check_eq("nom_valid_single", 32'(latency_valid), 32'd0);
        check_eq("nom_busy", 32'(busy), 32'd1);
        pulse_trigger();
        stray = 0;
        repeat (20) begin
            @(negedge clock);
            if (latency_valid) stray++;
        end
        check_eq("light_trig_no_strobe", 32'(stray), 32'd0);
        check_eq("light_trig_busy", 32'(busy), 32'd1);
        check_eq("light_trig_latency", latency, 32'd1000);
        go_dark("nom");

        // Glitch of 3 samples is shorter than the debounce run.
        pulse_trigger();
        repeat (499) @(negedge clock);
        sensor = 1'b1;
        repeat (3) @(negedge clock);
        sensor = 1'b0;
        repeat (297) @(negedge clock);
        sensor = 1'b1;
        wait_valid(40, n);
        check_eq("glitch_latency", latency, 32'd800);
        check_eq("glitch_strobe_delay", 32'(n), 32'd7);
        go_dark("glitch");

        // Second trigger at E300 while counting is ignored.
        pulse_trigger();
        repeat (299) @(negedge clock);
        pulse_trigger();
        repeat (699) @(negedge clock);
        sensor = 1'b1;
        wait_valid(40, n);
        check_eq("retrig_latency", latency, 32'd1000);
        check_eq("retrig_strobe_delay", 32'(n), 32'd7);
        go_dark("retrig");

        // Reset at counter = 300 aborts without a strobe.
        pulse_trigger();
        repeat (300) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_eq("abort_latency", latency, 32'd0);
        check_eq("abort_valid", 32'(latency_valid), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_eq("abort_idle", 32'(busy), 32'd0);
        measure("post_rst", 400, 32'd400);
        go_dark("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
